// File: rtl/pixel_matrix_loader.sv
// rtl/pixel_matrix_loader.sv - raster pixel stream to packed NxN matrix loader with convolution handshake
// Optional macro LOADER_SOF_EN adds the s_sof start-of-frame resync input.
module pixel_matrix_loader #(
    parameter int N  = 9,
    parameter int DW = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DW-1:0]       s_data,
    input  logic                s_valid,
`ifdef LOADER_SOF_EN
    input  logic                s_sof,
`endif
    output logic                s_ready,
    input  logic                conv_done,
    output logic                start,
    output logic [N*N*DW-1:0]   input_matrix,
    output logic                busy
);

    localparam int NN = N * N;
    localparam int IW = (NN > 1) ? $clog2(NN) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        START = 2'd2,
        WAIT  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic               s_ready_q, s_ready_d;
    logic               start_q, start_d;
    logic               busy_q, busy_d;
    logic [NN*DW-1:0]   matrix_q, matrix_d;

    logic               xfer;
    logic               sof;
    logic [IW-1:0]      wr_idx;
    logic               last_px;

    assign xfer = s_valid && s_ready_q;

`ifdef LOADER_SOF_EN
    assign sof = s_sof;
`else
    assign sof = 1'b0;
`endif

    // A start-of-frame pixel always lands in slot 0 and resyncs the counter.
    assign wr_idx  = sof ? '0 : idx_q;
    assign last_px = sof ? (NN == 1) : (idx_q == LAST_IDX);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        s_ready_d = s_ready_q;
        start_d   = 1'b0;
        busy_d    = busy_q;
        matrix_d  = matrix_q;
        case (state_q)
            IDLE: begin
                state_d   = FILL;
                s_ready_d = 1'b1;
            end
            FILL: begin
                if (xfer) begin
                    matrix_d[wr_idx*DW +: DW] = s_data;
                    if (last_px) begin
                        state_d   = START;
                        idx_d     = '0;
                        s_ready_d = 1'b0;
                        start_d   = 1'b1;
                        busy_d    = 1'b1;
                    end else begin
                        idx_d = sof ? IW'(1) : idx_q + 1'b1;
                    end
                end
            end
            START: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (conv_done) begin
                    state_d   = FILL;
                    idx_d     = '0;
                    s_ready_d = 1'b1;
                    busy_d    = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                s_ready_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            s_ready_q <= 1'b0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            matrix_q  <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            s_ready_q <= s_ready_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            matrix_q  <= matrix_d;
        end
    end

    assign s_ready      = s_ready_q;
    assign start        = start_q;
    assign busy         = busy_q;
    assign input_matrix = matrix_q;

endmodule

// File: doc/pixel_matrix_loader.md
PIXEL_MATRIX_LOADER -- requirements
Module: pixel_matrix_loader

Interface
REQ-001 The block SHALL have parameter N, default 9, the matrix side length in pixels.
REQ-002 The block SHALL have parameter DW, default 8, the pixel width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-005 The block SHALL have port s_data, input, DW bits, the incoming pixel in row-major raster order.
REQ-006 The block SHALL have port s_valid, input, 1 bit; high means s_data holds a pixel.
REQ-007 The block SHALL have port s_ready, output, 1 bit; high means the block accepts a pixel this cycle.
REQ-008 The block SHALL have port conv_done, input, 1 bit; high means the downstream convolution has finished with input_matrix.
REQ-009 The block SHALL have port start, output, 1 bit, a one-cycle request to the downstream convolution.
REQ-010 The block SHALL have port input_matrix, output, N*N*DW bits (648 at defaults), the packed pixel matrix.
REQ-011 The block SHALL have port busy, output, 1 bit; high while a full matrix is handed off (START or WAIT).

Function
REQ-012 A pixel transfer SHALL occur exactly in cycles where s_valid and s_ready are both high at the clock edge.
REQ-013 The block SHALL have FSM states IDLE, FILL, START, WAIT; IDLE→FILL unconditionally on the first edge after reset release.
REQ-014 In FILL, s_ready SHALL be 1 and transfer k (k = 0..N*N-1) SHALL write s_data to input_matrix[k*DW +: DW], i.e. pixel (i,j) at index i*N+j.
REQ-015 The pixel index counter SHALL be ceil(log2(N*N)) bits, increment by 1 per transfer, and return to 0 on leaving FILL; it SHALL never exceed N*N-1.
REQ-016 The transfer with k = N*N-1 SHALL move FILL→START; start SHALL be 1 in the following cycle, for exactly one cycle.
REQ-017 START→WAIT SHALL be unconditional after one cycle; in WAIT, s_ready SHALL be 0 and input_matrix SHALL hold stable.
REQ-018 In WAIT, conv_done=1 SHALL move WAIT→FILL with index 0; s_ready SHALL be 1 the cycle after conv_done is sampled.
REQ-019 conv_done SHALL be ignored in IDLE, FILL and START, and SHALL NOT retrigger start.
REQ-020 s_ready, start and busy SHALL be registered outputs; s_ready SHALL be 0 in IDLE, START and WAIT.
REQ-021 Pixels not yet overwritten in a new fill SHALL retain the previous matrix's values; no clearing between frames.
REQ-022 s_valid gaps of any length in FILL SHALL stall the index without corrupting stored pixels.

Reset
REQ-023 While rst=1: state IDLE, index 0, s_ready 0, start 0, busy 0, input_matrix all zeros.
REQ-024 Reset asserted mid-fill or in WAIT SHALL abandon the frame immediately; no start SHALL be issued for it.

Configuration
REQ-025 Macro LOADER_SOF_EN, when defined, SHALL add input port s_sof (1 bit, start-of-frame marker qualifying s_data).
REQ-026 With LOADER_SOF_EN, a FILL transfer with s_sof=1 SHALL write input_matrix[0 +: DW] and set index to 1 regardless of prior index (resync); at N*N=1 it SHALL go to START.
REQ-027 Without LOADER_SOF_EN, s_sof SHALL not exist and placement SHALL depend only on the transfer count.

Verification
REQ-028 Stream 0..80 with s_valid=1 continuously → input_matrix[(i*9+j)*8 +: 8] = i*9+j, start high exactly one cycle, the cycle after the 81st transfer; busy=1 from then.
REQ-029 Same stream with s_valid toggling 1,0,0,1,... → identical matrix; start one cycle after the 81st accepted pixel.
REQ-030 Hold s_valid=1 in WAIT for 20 cycles, then conv_done=1 for one cycle → no transfers during WAIT; s_ready=1 next cycle; next pixel 0xAA lands at bits [7:0].
REQ-031 Assert rst after 40 transfers, release, stream 81 pixels of 0x55 → matrix all 0x55, exactly one start pulse total.
REQ-032 Pulse conv_done during FILL at pixel 30 → no state change; start still follows the 81st transfer.
REQ-033 (LOADER_SOF_EN) Send 10 pixels, then s_sof=1 with 0x11 and 80 more pixels 1..80 → bits [7:0] = 0x11, start after those 81 pixels.
